ctrl_pipeline: RTL
==================

# ctrl_pipeline

- Pipelined control path for the CPU.
- Decodes the ID-stage opcode into the 11-bit control word and carries it, with its destination register, through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards across the integer and float register files, stalls for multi-cycle FPU operations, and squashes on taken branches.
- Sits between the ID stage and the datapath; the datapath consumes the per-stage control words directly.

## Interface
Parameters:
- FPU_LAT, 1: cycles an FPU op (opcode 1010011) occupies EX; legal range 1..15.
- CTRL_W, 11: control-word width.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  clock. **One clock; reset is asynchronous and active-low.**
- rstn  in  1  reset.
- valid_id  in  1  ID holds a real instruction.
- opcode_id  in  7  ID opcode.
- rs1_id, rs2_id, rd_id  in  REG_W each  ID register indices.
- branch_taken_ex  in  1  branch in EX resolved taken.
- ctrl_ex, ctrl_mem, ctrl_wb  out  CTRL_W each  per-stage control words.
- rd_ex, rd_mem, rd_wb  out  REG_W each  per-stage destinations.
- stall_if  out  1  hold PC and IF/ID.
- flush_if  out  1  squash IF/ID.
- illegal_id  out  1  valid_id with an unlisted opcode.

## Operation
Control word layout:
- [10] alusrc, [9] memtoreg, [8:7] regwrite (01 int, 10 float), [6] memread, [5] memwrite, [4] branch, [3:2] alu_op, [1] rs1_fpu, [0] rs2_fpu.

Decode table:
- nop 0000000 → 0x000
- addi 0010011 → 0x480
- R-type 0110011 → 0x088
- lw 0000011 → 0x6C0
- sw 0100011 → 0x420
- beq 1100011 → 0x014
- fpu 1010011 → 0x10F
- flw 0000111 → 0x740
- fsw 0100111 → 0x421
- Anything else → 0x000 with illegal_id=1.
- valid_id=0 forces 0x000 and illegal_id=0.

Source use:
- rs1 is used by every nonzero word except nop.
- rs2 is used by R-type, sw, beq, fpu and fsw.
- A source is float when its rs*_fpu bit is set.

Load-use hazard, combinational:
- Condition: ctrl_ex[6]=1 AND a used source in ID equals rd_ex AND the source's file matches ctrl_ex[8:7].
- Integer index 0 never hazards; float f0 does.
- Response: stall_if=1, and a bubble (0x000, rd 0) enters ID/EX next cycle.

FPU busy:
- When an FPU word enters EX with FPU_LAT>1, the down-counter loads FPU_LAT-1.
- While the counter is nonzero: stall_if=1, ID/EX holds, and EX/MEM receives a bubble each cycle.
- The word advances to MEM on the cycle the counter reaches zero.

Flush:
- branch_taken_ex=1 → flush_if=1 and the ID word is replaced by a bubble in ID/EX.
- Flush takes priority over the load-use stall; stall_if=0 that cycle.
- branch_taken_ex is ignored while FPU busy (EX cannot hold a branch then).

Reset:
- All ctrl_*/rd_* = 0, counter = 0.
- stall_if, flush_if, illegal_id = 0 while rstn=0 (they depend only on registered state plus gated inputs).

## Timing
- ID → ctrl_ex: 1 cycle. ctrl_ex → ctrl_mem: 1 cycle (FPU_LAT cycles for FPU ops). ctrl_mem → ctrl_wb: 1 cycle.
- stall_if, flush_if and illegal_id are combinational in the same cycle as their inputs.
- Load-use costs exactly one bubble.
- An FPU op costs FPU_LAT-1 stall cycles; FPU_LAT=1 stalls never.
- Back-to-back FPU ops: the second enters EX the cycle after the first leaves, then reloads the counter.
- Reset deasserted mid-operation: the pipeline restarts empty; no partial counter state survives.

## Configuration
- CTRL_PERF_EN defined: adds 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle stall_if=1; flush_cnt increments each cycle flush_if=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- CTRL_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- ctrl_pkg holds:
  - opcode constants;
  - control-word constants for each decoded class;
  - field bit indices;
  - regwrite encodings (RW_NONE=00, RW_INT=01, RW_FLT=10).
- One sub-module, ctrl_decode: combinational opcode → control word plus illegal flag.
- Hazard logic, stage registers and the busy counter live in ctrl_pipeline.

## Test plan
- Reset, then stream addi, R-type, lw, sw, beq, fpu, flw, fsw → ctrl_ex equals 0x480, 0x088, 0x6C0, 0x420, 0x014, 0x10F, 0x740, 0x421 on successive cycles, and ctrl_wb equals them 2 cycles later.
- lw rd=5, then add rs2=5 → stall_if=1 for exactly 1 cycle, ctrl_ex=0x000 for 1 cycle, then 0x088.
- flw rd=5, then add rs1=5 → no stall; then fpu rs1=f5 after flw rd=f5 → 1-cycle stall.
- lw rd=0, then addi rs1=0 → no stall.
- FPU_LAT=4, fpu op → stall_if high 3 cycles, ctrl_ex holds 0x10F for 4 cycles, ctrl_mem=0x000 for 3 cycles.
- beq in EX with branch_taken_ex=1 while ID holds a load-use hazard → flush_if=1, stall_if=0, next ctrl_ex=0x000.
- Opcode 1111111 with valid_id=1 → illegal_id=1, ctrl_ex=0x000.
- rstn pulled low mid-FPU stall → all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared constants for the pipelined control path: opcodes,
//               decoded control words, control-word field indices and
//               regwrite encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int CW_WIDTH = 11;
    localparam int RI_WIDTH = 5;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_FPU   = 7'b1010011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;

    // Control words per decoded class
    localparam logic [CW_WIDTH-1:0] CW_NOP   = 11'h000;
    localparam logic [CW_WIDTH-1:0] CW_ADDI  = 11'h480;
    localparam logic [CW_WIDTH-1:0] CW_RTYPE = 11'h088;
    localparam logic [CW_WIDTH-1:0] CW_LW    = 11'h6C0;
    localparam logic [CW_WIDTH-1:0] CW_SW    = 11'h420;
    localparam logic [CW_WIDTH-1:0] CW_BEQ   = 11'h014;
    localparam logic [CW_WIDTH-1:0] CW_FPU   = 11'h10F;
    localparam logic [CW_WIDTH-1:0] CW_FLW   = 11'h740;
    localparam logic [CW_WIDTH-1:0] CW_FSW   = 11'h421;

    // Control-word field bit indices
    localparam int CW_ALUSRC   = 10;
    localparam int CW_MEMTOREG = 9;
    localparam int CW_RW_HI    = 8;
    localparam int CW_RW_LO    = 7;
    localparam int CW_MEMREAD  = 6;
    localparam int CW_MEMWRITE = 5;
    localparam int CW_BRANCH   = 4;
    localparam int CW_ALUOP_HI = 3;
    localparam int CW_ALUOP_LO = 2;
    localparam int CW_RS1_FPU  = 1;
    localparam int CW_RS2_FPU  = 0;

    // regwrite field encodings
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_INT  = 2'b01;
    localparam logic [1:0] RW_FLT  = 2'b10;

    // True for instruction classes that read a second source register
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
               (opcode == OP_FPU)   || (opcode == OP_FSW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode to control-word decoder with illegal
//               opcode flag and second-source usage flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic                i_valid,
    input  logic [6:0]          i_opcode,
    output logic [CW_WIDTH-1:0] o_ctrl,
    output logic                o_illegal,
    output logic                o_rs2_used
);

    // Table lookup; an empty ID slot decodes to a quiet bubble
    always_comb begin
        o_ctrl     = CW_NOP;
        o_illegal  = 1'b0;
        o_rs2_used = 1'b0;
        if (i_valid) begin
            o_rs2_used = uses_rs2(i_opcode);
            case (i_opcode)
                OP_NOP:   o_ctrl = CW_NOP;
                OP_ADDI:  o_ctrl = CW_ADDI;
                OP_RTYPE: o_ctrl = CW_RTYPE;
                OP_LW:    o_ctrl = CW_LW;
                OP_SW:    o_ctrl = CW_SW;
                OP_BEQ:   o_ctrl = CW_BEQ;
                OP_FPU:   o_ctrl = CW_FPU;
                OP_FLW:   o_ctrl = CW_FLW;
                OP_FSW:   o_ctrl = CW_FSW;
                default: begin
                    o_ctrl     = CW_NOP;
                    o_illegal  = 1'b1;
                    o_rs2_used = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipeline.sv
// ============================================================================
// Module      : ctrl_pipeline
// Description : Pipelined control path. Decodes the ID opcode, carries the
//               control word and destination through ID/EX, EX/MEM and
//               MEM/WB, detects load-use hazards across integer and float
//               register files, stalls for multi-cycle FPU ops and squashes
//               on taken branches.
//               Optional build macro CTRL_PERF_EN adds saturating 32-bit
//               stall/flush event counters (o_stall_cnt, o_flush_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int FPU_LAT = 1,
    parameter int CTRL_W  = 11,
    parameter int REG_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid_id,
    input  logic [6:0]        i_opcode_id,
    input  logic [REG_W-1:0]  i_rs1_id,
    input  logic [REG_W-1:0]  i_rs2_id,
    input  logic [REG_W-1:0]  i_rd_id,
    input  logic              i_branch_taken_ex,
    output logic [CTRL_W-1:0] o_ctrl_ex,
    output logic [CTRL_W-1:0] o_ctrl_mem,
    output logic [CTRL_W-1:0] o_ctrl_wb,
    output logic [REG_W-1:0]  o_rd_ex,
    output logic [REG_W-1:0]  o_rd_mem,
    output logic [REG_W-1:0]  o_rd_wb,
    output logic              o_stall_if,
    output logic              o_flush_if,
`ifdef CTRL_PERF_EN
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt,
`endif
    output logic              o_illegal_id
);

    // Busy counter reload value; FPU_LAT=1 never reloads so never stalls
    localparam logic [3:0] c_BUSY_LOAD   = 4'(FPU_LAT - 1);
    localparam bit         c_MULTI_CYCLE = (FPU_LAT > 1);

    logic [CTRL_W-1:0] r_ctrl_ex, r_ctrl_mem, r_ctrl_wb;
    logic [REG_W-1:0]  r_rd_ex, r_rd_mem, r_rd_wb;
    logic [3:0]        r_busy_cnt;

    logic              w_valid;
    logic              w_branch;
    logic [CTRL_W-1:0] w_ctrl_id;
    logic              w_illegal;
    logic              w_rs2_used;
    logic              w_rs1_used;
    logic [REG_W-1:0]  w_rd_id;
    logic              w_busy;
    logic [1:0]        w_ex_rw;
    logic              w_hz_rs1, w_hz_rs2, w_hazard;
    logic              w_flush;
    logic              w_bubble_id;
    logic              w_fpu_enter;

    // Inputs are gated by reset so the combinational flags stay low in reset
    assign w_valid  = i_valid_id & rstn;
    assign w_branch = i_branch_taken_ex & rstn;

    ctrl_decode u_decode (
        .i_valid    (w_valid),
        .i_opcode   (i_opcode_id),
        .o_ctrl     (w_ctrl_id),
        .o_illegal  (w_illegal),
        .o_rs2_used (w_rs2_used)
    );

    // Any nonzero control word reads rs1; illegal/empty slots carry rd 0
    assign w_rs1_used = (w_ctrl_id != '0);
    assign w_rd_id    = (w_valid & ~w_illegal) ? i_rd_id : '0;

    assign w_busy  = (r_busy_cnt != 4'd0);
    assign w_ex_rw = r_ctrl_ex[CW_RW_HI:CW_RW_LO];

    // A source hazards when it reads the file the EX load writes; x0 is
    // hardwired so it is exempt, but f0 is an ordinary float register
    assign w_hz_rs1 = w_rs1_used && (i_rs1_id == r_rd_ex) &&
                      (w_ctrl_id[CW_RS1_FPU] ? (w_ex_rw == RW_FLT)
                                             : ((w_ex_rw == RW_INT) && (i_rs1_id != '0)));
    assign w_hz_rs2 = w_rs2_used && (i_rs2_id == r_rd_ex) &&
                      (w_ctrl_id[CW_RS2_FPU] ? (w_ex_rw == RW_FLT)
                                             : ((w_ex_rw == RW_INT) && (i_rs2_id != '0)));
    assign w_hazard = r_ctrl_ex[CW_MEMREAD] & (w_hz_rs1 | w_hz_rs2);

    // EX cannot hold a branch while the FPU is busy, so the branch is ignored
    assign w_flush     = w_branch & ~w_busy;
    assign w_bubble_id = w_flush | w_hazard;
    assign w_fpu_enter = c_MULTI_CYCLE & ~w_busy & ~w_bubble_id & (w_ctrl_id == CW_FPU);

    assign o_stall_if   = w_busy | (w_hazard & ~w_flush);
    assign o_flush_if   = w_flush;
    assign o_illegal_id = w_illegal;

    // FPU busy down-counter: loads when an FPU word enters EX
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy_cnt <= 4'd0;
        end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - 4'd1;
        end else if (w_fpu_enter) begin
            r_busy_cnt <= c_BUSY_LOAD;
        end
    end

    // ID/EX: hold while busy, bubble on flush or load-use, else take ID
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl_ex <= '0;
            r_rd_ex   <= '0;
        end else if (!w_busy) begin
            if (w_bubble_id) begin
                r_ctrl_ex <= '0;
                r_rd_ex   <= '0;
            end else begin
                r_ctrl_ex <= w_ctrl_id;
                r_rd_ex   <= w_rd_id;
            end
        end
    end

    // EX/MEM: bubble each cycle the FPU word is still occupying EX
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl_mem <= '0;
            r_rd_mem   <= '0;
        end else if (w_busy) begin
            r_ctrl_mem <= '0;
            r_rd_mem   <= '0;
        end else begin
            r_ctrl_mem <= r_ctrl_ex;
            r_rd_mem   <= r_rd_ex;
        end
    end

    // MEM/WB: always advances
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl_wb <= '0;
            r_rd_wb   <= '0;
        end else begin
            r_ctrl_wb <= r_ctrl_mem;
            r_rd_wb   <= r_rd_mem;
        end
    end

    assign o_ctrl_ex  = r_ctrl_ex;
    assign o_ctrl_mem = r_ctrl_mem;
    assign o_ctrl_wb  = r_ctrl_wb;
    assign o_rd_ex    = r_rd_ex;
    assign o_rd_mem   = r_rd_mem;
    assign o_rd_wb    = r_rd_wb;

`ifdef CTRL_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall_if && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (o_flush_if && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire
